// File: rtl/vz_pkg.sv
// vz_pkg: shared constants and state type for the VZ image uploader
package vz_pkg;
  localparam int HDR_LEN = 24;
  localparam int ADDR_W = 16;
  localparam logic [7:0] VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0] VZ_TYPE_BIN = 8'hF1;
  localparam logic [0:3][7:0] VZ_MAGIC = 32'h565A4630;
  localparam logic [0:16][7:0] VZ_NAME = {"LASER310", 72'h0};
  typedef enum logic [1:0] {IDLE, ARMED, FETCH, LOAD} state_e;
endpackage

// File: rtl/vz_header_rom.sv
// vz_header_rom: maps a header offset plus save parameters to the VZ header byte
module vz_header_rom
  import vz_pkg::*;
(
  input  logic [4:0] off,
  input  logic [7:0] vz_type,
  input  logic [15:0] start,
  output logic [7:0] data
);
  logic [4:0] ni;
  assign ni = off - 5'd4;
  assign data = off < 5'd4 ? VZ_MAGIC[off[1:0]] :
                off < 5'd21 ? VZ_NAME[ni] :
                off == 5'd21 ? vz_type :
                off == 5'd22 ? start[7:0] :
                off == 5'd23 ? start[15:8] : 8'h00;
endmodule

// File: rtl/vz_image_uploader.sv
// vz_image_uploader: serves a VZ header plus RAM bytes to the HPS upload path
module vz_image_uploader
  import vz_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  input  logic [15:0]       save_start,
  input  logic [15:0]       save_end,
  input  logic [7:0]        save_type,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  output logic              cpu_hold,
  output logic [16:0]       file_size,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e state_q, state_d;
  logic upload_q, upload_d;
  logic [15:0] start_q, start_d;
  logic [7:0] type_q, type_d;
  logic [16:0] file_size_q, file_size_d;
  logic act_q, act_d, done_q, done_d, err_q, err_d;
  logic [4:0] a_q, a_d;
  logic hdr_q, hdr_d, src_ram_q, src_ram_d, ram_rd_q, ram_rd_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0] byte_q, byte_d, din_q, din_d, rom_byte;
  logic rise, fall, in_hdr, in_ram;
  logic [16:0] len;
  vz_header_rom u_rom (.off(a_q), .vz_type(type_q), .start(start_q), .data(rom_byte));
  // next-state and datapath: falling upload edge overrides any request
  always_comb begin
    rise = ioctl_upload & ~upload_q;
    fall = ~ioctl_upload & upload_q;
    len = save_end >= save_start ? {1'b0, save_end - save_start} + 17'd1 : 17'd0;
    in_hdr = ioctl_addr < ADDR_W'(HDR_LEN);
    in_ram = !in_hdr && {1'b0, ioctl_addr} < file_size_q;
    state_d = state_q;
    upload_d = ioctl_upload;
    start_d = start_q;
    type_d = type_q;
    file_size_d = file_size_q;
    act_d = act_q;
    done_d = 1'b0;
    err_d = err_q;
    a_d = a_q;
    hdr_d = hdr_q;
    src_ram_d = src_ram_q;
    ram_rd_d = 1'b0;
    ram_addr_d = ram_addr_q;
    byte_d = byte_q;
    din_d = din_q;
    if (state_q == IDLE) begin
      if (rise) begin
        state_d = ARMED;
        start_d = save_start;
        type_d = save_type;
        file_size_d = 17'(HDR_LEN) + len;
        act_d = 1'b1;
        err_d = save_end < save_start;
      end
    end else if (fall) begin
      state_d = IDLE;
      act_d = 1'b0;
      done_d = 1'b1;
    end else if (state_q == ARMED) begin
      if (ioctl_rd) begin
        state_d = FETCH;
        a_d = ioctl_addr[4:0];
        hdr_d = in_hdr;
        src_ram_d = in_ram;
        ram_rd_d = in_ram;
        ram_addr_d = in_ram ? start_q + ioctl_addr - ADDR_W'(HDR_LEN) : ram_addr_q;
      end
    end else begin
      err_d = err_q | ioctl_rd;
      state_d = state_q == FETCH ? LOAD : ARMED;
      byte_d = state_q == FETCH ? (hdr_q ? rom_byte : 8'h00) : byte_q;
      din_d = state_q == LOAD ? (src_ram_q ? ram_dout : byte_q) : din_q;
    end
  end
  // state and output registers; upload history resets high so a held-high upload is not a new edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      upload_q <= 1'b1;
      start_q <= '0;
      type_q <= '0;
      file_size_q <= '0;
      act_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      a_q <= '0;
      hdr_q <= 1'b0;
      src_ram_q <= 1'b0;
      ram_rd_q <= 1'b0;
      ram_addr_q <= '0;
      byte_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      upload_q <= upload_d;
      start_q <= start_d;
      type_q <= type_d;
      file_size_q <= file_size_d;
      act_q <= act_d;
      done_q <= done_d;
      err_q <= err_d;
      a_q <= a_d;
      hdr_q <= hdr_d;
      src_ram_q <= src_ram_d;
      ram_rd_q <= ram_rd_d;
      ram_addr_q <= ram_addr_d;
      byte_q <= byte_d;
      din_q <= din_d;
    end
  end
  assign ioctl_din = din_q;
  assign ram_addr = ram_addr_q;
  assign ram_rd = ram_rd_q;
  assign cpu_hold = act_q;
  assign busy = act_q;
  assign file_size = file_size_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_vz_image_uploader.sv
// tb_vz_image_uploader: table-driven and sequence checks of the VZ uploader
module tb_vz_image_uploader;
  import vz_pkg::*;
  logic clk_sys = 0, reset = 1, ioctl_upload = 0, ioctl_rd = 0;
  logic [15:0] ioctl_addr = 0, save_start = 0, save_end = 0;
  logic [7:0] save_type = 0, ram_dout = 0, ioctl_din;
  logic [15:0] ram_addr;
  logic ram_rd, cpu_hold, busy, done, err;
  logic [16:0] file_size;
  int checks = 0, errors = 0;
  logic [7:0] last_din = 0;
  typedef struct {
    logic [15:0] off;
    logic [7:0] din;
    logic rd;
    logic [15:0] addr;
  } vec_t;
  vec_t vec[41];
  logic [7:0] hdr[24];

  vz_image_uploader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .save_start(save_start),
    .save_end(save_end), .save_type(save_type), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_dout(ram_dout), .cpu_hold(cpu_hold), .file_size(file_size), .busy(busy),
    .done(done), .err(err)
  );

  always #50 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (ram_rd) ram_dout <= ram_addr[7:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " din"}, 32'(ioctl_din), 0);
    chk({nm, " ram_addr"}, 32'(ram_addr), 0);
    chk({nm, " ram_rd"}, 32'(ram_rd), 0);
    chk({nm, " cpu_hold"}, 32'(cpu_hold), 0);
    chk({nm, " file_size"}, 32'(file_size), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " done"}, 32'(done), 0);
    chk({nm, " err"}, 32'(err), 0);
  endtask

  task automatic start_up(input logic [15:0] s, input logic [15:0] e, input logic [7:0] t,
                          input logic [16:0] fs, input logic er);
    @(negedge clk_sys);
    save_start = s; save_end = e; save_type = t; ioctl_upload = 1;
    @(negedge clk_sys);
    chk("start busy", 32'(busy), 1);
    chk("start cpu_hold", 32'(cpu_hold), 1);
    chk("start file_size", 32'(file_size), 32'(fs));
    chk("start err", 32'(err), 32'(er));
  endtask

  task automatic stop_up();
    @(negedge clk_sys);
    ioctl_upload = 0;
    @(negedge clk_sys);
    chk("stop done", 32'(done), 1);
    chk("stop busy", 32'(busy), 0);
    chk("stop cpu_hold", 32'(cpu_hold), 0);
    @(negedge clk_sys);
    chk("stop done pulse", 32'(done), 0);
  endtask

  task automatic rd_vec(input logic [15:0] off, input logic [7:0] din, input logic rd,
                        input logic [15:0] addr);
    @(negedge clk_sys);
    ioctl_rd = 1; ioctl_addr = off;
    @(negedge clk_sys);
    ioctl_rd = 0;
    chk($sformatf("ram_rd fetch off=%0d", off), 32'(ram_rd), 32'(rd));
    if (rd) chk($sformatf("ram_addr off=%0d", off), 32'(ram_addr), 32'(addr));
    @(negedge clk_sys);
    chk($sformatf("ram_rd single off=%0d", off), 32'(ram_rd), 0);
    chk($sformatf("din hold off=%0d", off), 32'(ioctl_din), 32'(last_din));
    @(negedge clk_sys);
    chk($sformatf("din off=%0d", off), 32'(ioctl_din), 32'(din));
    last_din = din;
  endtask

  initial begin
    hdr = '{8'h56, 8'h5A, 8'h46, 8'h30, 8'h4C, 8'h41, 8'h53, 8'h45, 8'h52, 8'h33, 8'h31, 8'h30,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            VZ_TYPE_BASIC, 8'hE9, 8'h7A};
    for (int i = 0; i < 24; i++) vec[i] = '{16'(i), hdr[i], 1'b0, 16'h0};
    for (int i = 24; i < 40; i++) vec[i] = '{16'(i), 8'hE9 + 8'(i - 24), 1'b1, 16'h7AE9 + 16'(i - 24)};
    vec[40] = '{16'd40, 8'h00, 1'b0, 16'h0};

    repeat (3) @(negedge clk_sys);
    chk_zero("reset");
    reset = 0;
    @(negedge clk_sys);

    start_up(16'h7AE9, 16'h7AF8, VZ_TYPE_BASIC, 17'd40, 1'b0);
    for (int i = 0; i < 41; i++) rd_vec(vec[i].off, vec[i].din, vec[i].rd, vec[i].addr);

    @(negedge clk_sys);
    ioctl_rd = 1; ioctl_addr = 0;
    @(negedge clk_sys);
    ioctl_addr = 5;
    @(negedge clk_sys);
    ioctl_rd = 0;
    @(negedge clk_sys);
    chk("protocol din", 32'(ioctl_din), 32'h56);
    chk("protocol err", 32'(err), 1);
    last_din = 8'h56;
    rd_vec(16'd22, 8'hE9, 1'b0, 16'h0);
    chk("protocol err sticky", 32'(err), 1);
    stop_up();

    start_up(16'hFFFE, 16'hFFFF, VZ_TYPE_BIN, 17'd26, 1'b0);
    rd_vec(16'd21, VZ_TYPE_BIN, 1'b0, 16'h0);
    rd_vec(16'd24, 8'hFE, 1'b1, 16'hFFFE);
    rd_vec(16'd25, 8'hFF, 1'b1, 16'hFFFF);
    rd_vec(16'd26, 8'h00, 1'b0, 16'h0);
    rd_vec(16'd23, 8'hFF, 1'b0, 16'h0);
    stop_up();

    start_up(16'hFFFE, 16'h0001, VZ_TYPE_BIN, 17'd24, 1'b1);
    rd_vec(16'd24, 8'h00, 1'b0, 16'h0);
    stop_up();

    start_up(16'h1000, 16'h1003, VZ_TYPE_BASIC, 17'd28, 1'b0);
    @(negedge clk_sys);
    ioctl_rd = 1; ioctl_addr = 24;
    @(negedge clk_sys);
    ioctl_rd = 0; ioctl_upload = 0;
    chk("abort ram_rd", 32'(ram_rd), 1);
    @(negedge clk_sys);
    chk("abort done", 32'(done), 1);
    chk("abort busy", 32'(busy), 0);
    chk("abort cpu_hold", 32'(cpu_hold), 0);
    @(negedge clk_sys);
    chk("abort done pulse", 32'(done), 0);
    chk("abort din kept", 32'(ioctl_din), 32'(last_din));

    start_up(16'h7AE9, 16'h7AF8, VZ_TYPE_BIN, 17'd40, 1'b0);
    @(negedge clk_sys);
    ioctl_rd = 1; ioctl_addr = 30;
    @(negedge clk_sys);
    ioctl_rd = 0; reset = 1;
    @(negedge clk_sys);
    chk_zero("mid reset");
    reset = 0;
    repeat (3) @(negedge clk_sys);
    chk("no restart busy", 32'(busy), 0);
    chk("no restart hold", 32'(cpu_hold), 0);
    ioctl_upload = 0;
    @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
